// File: rtl/add_parity_pipe_stage.sv
// One valid/payload register of the elastic pipeline; holds its contents
// while occupied and the downstream stage cannot take them.
module pipe_valid_stage #(
    parameter int WIDTH_P = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH_P-1:0] in_data,
    input  logic               next_advance,
    output logic               valid,
    output logic [WIDTH_P-1:0] data,
    output logic               advance
);

    assign advance = !valid || next_advance;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (advance) begin
            valid <= in_valid;
            data  <= in_data;
        end
    end

endmodule

// File: rtl/add_parity_pipe.sv
// Three-stage capture / add-constant / parity pipeline with valid-ready flow
// control, carry-out and a saturating count of completed output transfers.
module add_parity_pipe #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] ADD_CONST = WIDTH'(8'h55),
    parameter int               COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               odd_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_carry,
    output logic               out_parity,
    output logic [COUNT_W-1:0] xfer_count,
    output logic               count_sat
);

    function automatic logic parity_bit(input logic [WIDTH-1:0] value, input logic odd);
        return (^value) ^ odd;
    endfunction

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

    logic               vld_p0, vld_p1, vld_p2;
    logic               adv_p0, adv_p1, adv_p2;
    logic [WIDTH:0]     dat_p0;
    logic [WIDTH+1:0]   dat_p1, dat_p2;
    logic [WIDTH:0]     sum_p1;
    logic               par_p2;

    assign in_ready = rst && adv_p0;

    // Stage 0: capture item with its parity sense
    pipe_valid_stage #(.WIDTH_P(WIDTH + 1)) u_stage_p0 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      ({odd_mode, in_data}),
        .next_advance (adv_p1),
        .valid        (vld_p0),
        .data         (dat_p0),
        .advance      (adv_p0)
    );

    // Stage 1: add constant; payload is {odd_mode, carry, sum}
    assign sum_p1 = {1'b0, dat_p0[WIDTH-1:0]} + {1'b0, ADD_CONST};

    pipe_valid_stage #(.WIDTH_P(WIDTH + 2)) u_stage_p1 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (vld_p0),
        .in_data      ({dat_p0[WIDTH], sum_p1}),
        .next_advance (adv_p2),
        .valid        (vld_p1),
        .data         (dat_p1),
        .advance      (adv_p1)
    );

    // Stage 2: parity of the same item's sum; payload is {parity, carry, sum}
    assign par_p2 = parity_bit(dat_p1[WIDTH-1:0], dat_p1[WIDTH+1]);

    pipe_valid_stage #(.WIDTH_P(WIDTH + 2)) u_stage_p2 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (vld_p1),
        .in_data      ({par_p2, dat_p1[WIDTH:0]}),
        .next_advance (out_ready),
        .valid        (vld_p2),
        .data         (dat_p2),
        .advance      (adv_p2)
    );

    assign out_valid  = vld_p2;
    assign out_data   = dat_p2[WIDTH-1:0];
    assign out_carry  = dat_p2[WIDTH];
    assign out_parity = dat_p2[WIDTH+1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            xfer_count <= '0;
        end else if (out_valid && out_ready) begin
            xfer_count <= sat_inc(xfer_count);
        end
    end

    assign count_sat = &xfer_count;

endmodule

// File: tb/tb_add_parity_pipe.sv
// Directed checks on an 8-bit / 4-bit-counter instance plus a randomised
// scoreboard run on a 13-bit instance.
module tb_add_parity_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       a_in_valid = 1'b0, a_in_ready, a_odd = 1'b0;
    logic [7:0] a_in_data = '0, a_out_data;
    logic       a_out_valid, a_out_ready = 1'b0, a_out_carry, a_out_parity;
    logic [3:0] a_xfer_count;
    logic       a_count_sat;

    add_parity_pipe #(.WIDTH(8), .ADD_CONST(8'h55), .COUNT_W(4)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_data    (a_in_data),
        .odd_mode   (a_odd),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_data   (a_out_data),
        .out_carry  (a_out_carry),
        .out_parity (a_out_parity),
        .xfer_count (a_xfer_count),
        .count_sat  (a_count_sat)
    );

    // 13-bit instance
    localparam logic [12:0] B_CONST = 13'h1ABC;
    logic        b_in_valid = 1'b0, b_in_ready, b_odd = 1'b0;
    logic [12:0] b_in_data = '0, b_out_data;
    logic        b_out_valid, b_out_ready = 1'b0, b_out_carry, b_out_parity;
    logic [15:0] b_xfer_count;
    logic        b_count_sat;

    add_parity_pipe #(.WIDTH(13), .ADD_CONST(B_CONST), .COUNT_W(16)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_data    (b_in_data),
        .odd_mode   (b_odd),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_data   (b_out_data),
        .out_carry  (b_out_carry),
        .out_parity (b_out_parity),
        .xfer_count (b_xfer_count),
        .count_sat  (b_count_sat)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed vectors for the streaming test
    logic [7:0] t1_in  [4] = '{8'h00, 8'hB0, 8'h01, 8'h02};
    logic [7:0] t1_out [4] = '{8'h55, 8'h05, 8'h56, 8'h57};
    logic       t1_cy  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       t1_par [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] t3_out [3] = '{8'h65, 8'h66, 8'h67};
    logic       t3_par [3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        int          acc;
        int          exp_cnt;
        int          sent, recvd, cyc;
        logic [13:0] q[$];
        logic [13:0] e;
        logic [13:0] esum;

        // Reset state
        rst = 1'b0;
        step();
        step();
        check("rst_out_valid", a_out_valid, 0);
        check("rst_in_ready", a_in_ready, 0);
        check("rst_xfer_count", a_xfer_count, 0);
        check("rst_count_sat", a_count_sat, 0);
        rst = 1'b1;
        #1;
        check("post_rst_in_ready", a_in_ready, 1);

        // Back-to-back stream, even parity
        a_out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            a_in_valid = (c < 4);
            if (c < 4) a_in_data = t1_in[c];
            step();
            if (c >= 2 && c < 6) begin
                check("t1_valid", a_out_valid, 1);
                check("t1_data", a_out_data, t1_out[c-2]);
                check("t1_carry", a_out_carry, t1_cy[c-2]);
                check("t1_parity", a_out_parity, t1_par[c-2]);
            end else if (c == 6) begin
                check("t1_drained", a_out_valid, 0);
            end
        end
        check("t1_count", a_xfer_count, 4);

        // Odd parity sense, changed after acceptance
        a_in_valid = 1'b1; a_in_data = 8'h01; a_odd = 1'b1;
        step();
        a_in_valid = 1'b0; a_odd = 1'b0;
        step();
        step();
        check("t2_valid", a_out_valid, 1);
        check("t2_data", a_out_data, 8'h56);
        check("t2_parity", a_out_parity, 1);
        step();
        check("t2_count", a_xfer_count, 5);

        // Backpressure: fill, hold, release
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            a_in_data = 8'h10 + 8'(acc);
            #1;
            if (a_in_ready) acc++;
            step();
            if (c >= 3) begin
                check("t3_hold_valid", a_out_valid, 1);
                check("t3_hold_data", a_out_data, 8'h65);
            end
        end
        check("t3_accepted", acc, 3);
        check("t3_in_ready_low", a_in_ready, 0);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t3_rel_valid", a_out_valid, 1);
            check("t3_rel_data", a_out_data, t3_out[k]);
            check("t3_rel_parity", a_out_parity, t3_par[k]);
            step();
        end
        check("t3_drained", a_out_valid, 0);
        check("t3_count", a_xfer_count, 8);

        // Reset with two items in flight
        a_in_valid = 1'b1; a_in_data = 8'hA0;
        step();
        a_in_data = 8'hA1;
        step();
        a_in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("t4_in_ready_rst", a_in_ready, 0);
        step();
        rst = 1'b1;
        #1;
        check("t4_in_ready_after", a_in_ready, 1);
        check("t4_count", a_xfer_count, 0);
        for (int c = 0; c < 3; c++) begin
            check("t4_no_valid", a_out_valid, 0);
            step();
        end

        // Saturation of the transfer counter
        for (int t = 0; t < 25; t++) begin
            a_in_valid = (t < 20);
            a_in_data  = 8'(t);
            step();
            exp_cnt = t + 1 - 3;
            if (exp_cnt < 0) exp_cnt = 0;
            if (exp_cnt > 15) exp_cnt = 15;
            check("t5_count", a_xfer_count, exp_cnt);
            check("t5_sat", a_count_sat, (exp_cnt == 15));
        end
        a_in_valid = 1'b0;

        // Random handshakes on the 13-bit instance
        sent = 0; recvd = 0; cyc = 0;
        while (recvd < 1000 && cyc < 20000) begin
            b_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            b_in_data   = 13'($urandom);
            b_odd       = 1'($urandom);
            b_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (b_in_valid && b_in_ready) begin
                q.push_back({b_odd, b_in_data});
                sent++;
            end
            if (b_out_valid && b_out_ready) begin
                if (q.size() == 0) begin
                    check("t6_spurious", 1, 0);
                end else begin
                    e    = q.pop_front();
                    esum = {1'b0, e[12:0]} + {1'b0, B_CONST};
                    check("t6_data", b_out_data, esum[12:0]);
                    check("t6_carry", b_out_carry, esum[13]);
                    check("t6_parity", b_out_parity, (^esum[12:0]) ^ e[13]);
                end
                recvd++;
            end
            step();
            cyc++;
        end
        b_in_valid = 1'b0;
        check("t6_items", recvd, 1000);
        check("t6_count", b_xfer_count, 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
